// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the Canny gradient CORDIC chain.
//   ANGLE_W   : width of the accumulated CORDIC angle (2^32 = 360 degrees)
//   ANG_22_5  : 22.5 degrees in angle units, half of one NMS direction bin
//   ANG_180   : 180 degrees in angle units; it is also the MSB of the angle word
//   dir_t     : 2-bit non-maximum-suppression direction code
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam int ANGLE_W = 32;

   localparam logic [ANGLE_W-1:0] ANG_22_5 = 32'h1000_0000;
   localparam logic [ANGLE_W-1:0] ANG_180  = 32'h8000_0000;

   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } dir_t;

endpackage

// File: rtl/pix_pos_cnt.sv
// -----------------------------------------------------------------------------
// pix_pos_cnt
// Column/row position tracker for a raster-scanned frame, with start-of-frame
// resynchronisation. The flags describe the pixel presented this cycle and are
// combinational from the counter state and sof_in.
//   clk, rst   : clock and synchronous active-high reset (counters -> 0,0)
//   valid_in   : a pixel is presented this cycle; counters advance only then
//   sof_in     : the presented pixel is (0,0); ignored when valid_in=0
//   border     : presented pixel lies on the first/last row or column
//   eof        : presented pixel is the last pixel of the frame
// -----------------------------------------------------------------------------
module pix_pos_cnt #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   input  logic sof_in,
   output logic border,
   output logic eof
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_nxt_s;
   logic [ROW_W-1:0] row_nxt_s;
   logic [COL_W-1:0] cur_col_s;
   logic [ROW_W-1:0] cur_row_s;
   logic             sof_v_s;
   logic             last_col_s;
   logic             last_row_s;

   // Position of the presented pixel: a qualified sof forces (0,0) at once.
   always_comb begin
      sof_v_s   = valid_in & sof_in;
      cur_col_s = col_r;
      cur_row_s = row_r;
      if (sof_v_s) begin
         cur_col_s = {COL_W{1'b0}};
         cur_row_s = {ROW_W{1'b0}};
      end else begin
         cur_col_s = col_r;
         cur_row_s = row_r;
      end
      last_col_s = (cur_col_s == COL_LAST);
      last_row_s = (cur_row_s == ROW_LAST);
      border     = (cur_col_s == {COL_W{1'b0}}) | last_col_s |
                   (cur_row_s == {ROW_W{1'b0}}) | last_row_s;
      eof        = last_col_s & last_row_s;
   end

   // Position following the presented pixel, wrapping at line and frame end.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (valid_in) begin
         if (last_col_s) begin
            col_nxt_s = {COL_W{1'b0}};
            if (last_row_s) begin
               row_nxt_s = {ROW_W{1'b0}};
            end else begin
               row_nxt_s = cur_row_s + ROW_W'(1'b1);
            end
         end else begin
            col_nxt_s = cur_col_s + COL_W'(1'b1);
            row_nxt_s = cur_row_s;
         end
      end else begin
         col_nxt_s = col_r;
         row_nxt_s = row_r;
      end
   end

   // Counter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r <= {COL_W{1'b0}};
         row_r <= {ROW_W{1'b0}};
      end else begin
         col_r <= col_nxt_s;
         row_r <= row_nxt_s;
      end
   end

endmodule

// File: rtl/cordic_grad_post.sv
// -----------------------------------------------------------------------------
// cordic_grad_post
// Output stage of the Canny gradient CORDIC chain. Turns the vectored x and the
// accumulated angle of the last CORDIC stage into a gain-compensated magnitude,
// a 2-bit NMS direction and frame position flags. Border pixels get a zero
// magnitude so that NMS never looks outside the image. Two-cycle latency.
//   clk, rst    : clock and synchronous active-high reset
//   valid_in    : x_in/rot_in/sof_in carry a pixel
//   sof_in      : first pixel of a frame (qualified by valid_in)
//   x_in        : signed vectored x (magnitude times CORDIC gain)
//   rot_in      : accumulated angle, 2^32 = 360 degrees
//   valid_out   : outputs carry a pixel (valid_in delayed by two cycles)
//   mag_out     : compensated magnitude, 0 on border pixels
//   dir_out     : 0=0, 1=45, 2=90, 3=135 degrees
//   border_out  : pixel is on the first/last row or column
//   eof_out     : pixel is the last pixel of the frame
// Data outputs hold their previous value while valid_out is low.
// -----------------------------------------------------------------------------
module cordic_grad_post
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH_IN = 11,
   parameter int MAG_WIDTH     = DATA_WIDTH_IN - 1,
   parameter int IMG_W         = 640,
   parameter int IMG_H         = 480
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid_in,
   input  logic                            sof_in,
   input  logic signed [DATA_WIDTH_IN-1:0] x_in,
   input  logic        [ANGLE_W-1:0]       rot_in,
   output logic                            valid_out,
   output logic        [MAG_WIDTH-1:0]     mag_out,
   output logic        [1:0]               dir_out,
   output logic                            border_out,
   output logic                            eof_out
);

   logic [DATA_WIDTH_IN:0] xp_s;
   logic [MAG_WIDTH-1:0]   mag_s;
   dir_t                   dir_s;
   logic                   border_s;
   logic                   eof_s;

   logic                   vld1_r;
   logic [MAG_WIDTH-1:0]   mag1_r;
   dir_t                   dir1_r;
   logic                   border1_r;
   logic                   eof1_r;

   pix_pos_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_pix_pos_cnt (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .sof_in   (sof_in),
      .border   (border_s),
      .eof      (eof_s)
   );

   // Negative x is clamped to zero, then scaled by ~0.60742 with four floored
   // shift terms. The result never exceeds xp, so truncation cannot overflow.
   always_comb begin
      xp_s = {(DATA_WIDTH_IN+1){1'b0}};
      if (x_in[DATA_WIDTH_IN-1]) begin
         xp_s = {(DATA_WIDTH_IN+1){1'b0}};
      end else begin
         xp_s = {1'b0, x_in};
      end
      mag_s = MAG_WIDTH'((xp_s >> 4'd1) + (xp_s >> 4'd3)
                       - (xp_s >> 4'd6) - (xp_s >> 4'd9));
   end

   // Direction modulo 180 degrees: dropping the MSB folds the angle into one
   // half-turn, adding 22.5 degrees centres the bins, and bits [30:29] of the
   // sum pick the 45-degree bin (boundary values land in the higher bin).
   always_comb begin
      dir_s = dir_t'(2'(((rot_in & ~ANG_180) + ANG_22_5) >> 5'd29));
   end

   // Stage 1: register magnitude, direction and position flags of each pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld1_r    <= 1'b0;
         mag1_r    <= {MAG_WIDTH{1'b0}};
         dir1_r    <= DIR_0;
         border1_r <= 1'b0;
         eof1_r    <= 1'b0;
      end else begin
         vld1_r <= valid_in;
         if (valid_in) begin
            mag1_r    <= mag_s;
            dir1_r    <= dir_s;
            border1_r <= border_s;
            eof1_r    <= eof_s;
         end
      end
   end

   // Stage 2: apply the border mask and register the outputs; data holds on
   // bubbles so downstream sees stable values when valid_out is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out  <= 1'b0;
         mag_out    <= {MAG_WIDTH{1'b0}};
         dir_out    <= 2'd0;
         border_out <= 1'b0;
         eof_out    <= 1'b0;
      end else begin
         valid_out <= vld1_r;
         if (vld1_r) begin
            mag_out    <= border1_r ? {MAG_WIDTH{1'b0}} : mag1_r;
            dir_out    <= dir1_r;
            border_out <= border1_r;
            eof_out    <= eof1_r;
         end
      end
   end

endmodule

// File: tb/tb_cordic_grad_post.sv
// -----------------------------------------------------------------------------
// tb_cordic_grad_post
// Self-checking bench for cordic_grad_post on a 4x3 image. A behavioural model
// tracks the pixel index within the frame, computes magnitude and direction
// with integer arithmetic and delays results through a queue; the DUT outputs
// are compared every cycle. Directed sequences add fixed expected values.
// -----------------------------------------------------------------------------
module tb_cordic_grad_post;

   localparam int DW    = 11;
   localparam int MW    = DW - 1;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 valid_in;
   logic                 sof_in;
   logic signed [DW-1:0] x_in;
   logic        [31:0]   rot_in;
   logic                 valid_out;
   logic        [MW-1:0] mag_out;
   logic        [1:0]    dir_out;
   logic                 border_out;
   logic                 eof_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit v;
      int mag;
      int dir;
      bit border;
      bit eof;
   } exp_t;

   exp_t q[$];
   exp_t held = '{default: 0};
   int   pix  = 0;

   cordic_grad_post #(
      .DATA_WIDTH_IN (DW),
      .MAG_WIDTH     (MW),
      .IMG_W         (IMG_W),
      .IMG_H         (IMG_H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .sof_in     (sof_in),
      .x_in       (x_in),
      .rot_in     (rot_in),
      .valid_out  (valid_out),
      .mag_out    (mag_out),
      .dir_out    (dir_out),
      .border_out (border_out),
      .eof_out    (eof_out)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // K ~ 0.60742 scaling of the clamped x, floor at every term.
   function automatic int model_mag(input int x);
      int xp;
      xp = (x < 0) ? 0 : x;
      return xp / 2 + xp / 8 - xp / 64 - xp / 512;
   endfunction

   // Angle folded to [0,180) degrees, shifted by 22.5 degrees, 45-degree bins.
   function automatic int model_dir(input logic [31:0] rot);
      longint a;
      longint half_turn;
      half_turn = 64'd2147483648;
      a = longint'(rot) % half_turn;
      return int'(((a + 64'd268435456) % half_turn) / 64'd536870912);
   endfunction

   // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
   task automatic step(input bit r, input bit v, input bit s, input int x, input logic [31:0] a);
      exp_t        rec;
      exp_t        due;
      int          col;
      int          row;
      logic [31:0] xv;
      rst      = r;
      valid_in = v;
      sof_in   = s;
      xv       = x;
      x_in     = xv[DW-1:0];
      rot_in   = a;
      @(posedge clk);
      due = '{default: 0};
      if (r) begin
         q.delete();
         pix  = 0;
         held = '{default: 0};
      end else begin
         rec = '{default: 0};
         if (v) begin
            if (s) pix = 0;
            col        = pix % IMG_W;
            row        = pix / IMG_W;
            rec.v      = 1'b1;
            rec.border = (col == 0 || col == IMG_W - 1 || row == 0 || row == IMG_H - 1);
            rec.eof    = (pix == IMG_W * IMG_H - 1);
            rec.mag    = rec.border ? 0 : model_mag(x);
            rec.dir    = model_dir(a);
            pix        = (pix + 1) % (IMG_W * IMG_H);
         end
         q.push_back(rec);
         if (q.size() > 1) due = q.pop_front();
         if (due.v) held = due;
      end
      #1;
      check_value("valid_out", {31'd0, valid_out}, {31'd0, due.v});
      check_value("mag_out", {22'd0, mag_out}, held.mag);
      check_value("dir_out", {30'd0, dir_out}, held.dir);
      check_value("border_out", {31'd0, border_out}, {31'd0, held.border});
      check_value("eof_out", {31'd0, eof_out}, {31'd0, held.eof});
   endtask

   initial begin
      logic [31:0] dir_rots [6];
      logic [1:0]  dir_exp  [6];
      logic [11:0] border_map;
      logic [6:0]  vpat;

      dir_rots = '{32'h0FFF_FFFF, 32'h1000_0000, 32'h3000_0000,
                   32'h5000_0000, 32'h7000_0000, 32'h9000_0000};
      dir_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      border_map = 12'b1111_1001_1111;
      vpat       = 7'b0001101;

      step(1'b1, 1'b0, 1'b0, 0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 0, 32'd0);

      // Positive and negative magnitude on the two interior pixels.
      step(1'b0, 1'b1, 1'b1, 0, 32'd0);
      for (int i = 1; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1000, 32'd0);
      step(1'b0, 1'b1, 1'b0, -5, 32'd0);
      check_value("mag_1000", {22'd0, mag_out}, 32'd609);
      check_value("dir_1000", {30'd0, dir_out}, 32'd0);
      check_value("valid_1000", {31'd0, valid_out}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 0, 32'd0);
      check_value("mag_neg", {22'd0, mag_out}, 32'd0);
      check_value("border_neg", {31'd0, border_out}, 32'd0);
      for (int i = 8; i < 12; i++) step(1'b0, 1'b1, 1'b0, 0, 32'd0);

      // Direction bins including exact boundaries.
      for (int k = 0; k < 7; k++) begin
         step(1'b0, k < 6, k == 0, 300, (k < 6) ? dir_rots[k] : 32'd0);
         if (k >= 1) check_value("dir_bin", {30'd0, dir_out}, {30'd0, dir_exp[k-1]});
      end

      // Border map of a full 4x3 frame.
      for (int k = 0; k < 13; k++) begin
         step(1'b0, k < 12, k == 0, 100, 32'd0);
         if (k >= 1) begin
            check_value("map_border", {31'd0, border_out}, {31'd0, border_map[k-1]});
            check_value("map_mag", {22'd0, mag_out}, border_map[k-1] ? 32'd0 : 32'd61);
            check_value("map_eof", {31'd0, eof_out}, (k == 12) ? 32'd1 : 32'd0);
         end
      end

      // Bubbles preserved.
      for (int k = 0; k < 7; k++) begin
         step(1'b0, vpat[k], 1'b0, 200, 32'h2000_0000);
         if (k >= 1) check_value("bubble_valid", {31'd0, valid_out}, {31'd0, vpat[k-1]});
      end

      // Mid-frame resync on the fifth pixel.
      step(1'b0, 1'b1, 1'b1, 500, 32'd0);
      for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 1'b0, 500, 32'd0);
      step(1'b0, 1'b1, 1'b1, 500, 32'd0);
      step(1'b0, 1'b0, 1'b0, 0, 32'd0);
      check_value("resync_border", {31'd0, border_out}, 32'd1);
      check_value("resync_mag", {22'd0, mag_out}, 32'd0);

      // Reset with two pixels in flight.
      step(1'b0, 1'b1, 1'b0, 1000, 32'h4000_0000);
      step(1'b0, 1'b1, 1'b0, 1000, 32'h4000_0000);
      step(1'b1, 1'b1, 1'b0, 1000, 32'h4000_0000);
      check_value("rst_valid", {31'd0, valid_out}, 32'd0);
      check_value("rst_mag", {22'd0, mag_out}, 32'd0);
      check_value("rst_dir", {30'd0, dir_out}, 32'd0);
      check_value("rst_border", {31'd0, border_out}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1000, 32'd0);
      check_value("rst_flush", {31'd0, valid_out}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 0, 32'd0);
      check_value("rst_first_valid", {31'd0, valid_out}, 32'd1);
      check_value("rst_first_border", {31'd0, border_out}, 32'd1);

      // Randomised traffic with occasional sof, bubbles and resets.
      for (int i = 0; i < 2000; i++) begin
         bit          r;
         bit          v;
         bit          s;
         int          x;
         logic [31:0] a;
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 15) == 0);
         x = int'($urandom_range(0, 2047)) - 1024;
         a = $urandom;
         step(r, v, s, x, a);
      end
      step(1'b0, 1'b0, 1'b0, 0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_grad_post.md
# cordic_grad_post

Output stage of the Canny gradient CORDIC chain. Consumes the final pipeline stage's vectored x (magnitude × CORDIC gain) and accumulated angle. Produces:
- a gain-compensated unsigned magnitude;
- a 2-bit non-maximum-suppression direction;
- per-pixel frame position flags.

Border pixels have their magnitude forced to zero so NMS never reads outside the image.

## Interface
Parameters:
- DATA_WIDTH_IN, 11: signed width of x_in.
- MAG_WIDTH, DATA_WIDTH_IN-1: unsigned magnitude width.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  x_in/rot_in/sof_in carry a pixel this cycle.
- sof_in  in  1  qualifies the first pixel of a frame; ignored when valid_in=0.
- x_in  in  DATA_WIDTH_IN  signed vectored x from the last CORDIC stage.
- rot_in  in  32  accumulated angle; 2^32 = 360°, unsigned wrap.
- valid_out  out  1  outputs carry a pixel.
- mag_out  out  MAG_WIDTH  compensated magnitude; 0 on border pixels.
- dir_out  out  2  0=0°, 1=45°, 2=90°, 3=135°.
- border_out  out  1  pixel is on row 0, row IMG_H-1, col 0 or col IMG_W-1.
- eof_out  out  1  pixel is row IMG_H-1, col IMG_W-1.

## Operation
- Streaming only, no backpressure. One pixel is accepted on every cycle with valid_in=1.
- Magnitude:
  - xp = max(x_in, 0).
  - m = (xp>>1) + (xp>>3) − (xp>>6) − (xp>>9), each shift floored, computed in DATA_WIDTH_IN+1 bits. Approximates K ≈ 0.60742.
  - m ≤ xp always, so there is no saturation; truncate to MAG_WIDTH.
- Direction, taken modulo 180°:
  - a = rot_in[30:0].
  - dir = (a + 2^28) mod 2^31, bits [30:29].
  - Resulting bins: [−22.5°, 22.5°)→0, [22.5°, 67.5°)→1, [67.5°, 112.5°)→2, [112.5°, 157.5°)→3.
  - A value exactly on a boundary goes to the higher bin.
- Position tracking (col, row counters):
  - Counters advance only on valid_in.
  - sof_in=1 with valid_in=1: the current pixel is (0,0). Next position is (1,0).
  - Otherwise the current pixel takes the counter value. Col wraps at IMG_W-1 and row increments. At (IMG_W-1, IMG_H-1) both wrap to (0,0).
  - sof_in mid-frame: resynchronise immediately. No error flag.
- Border: border_out = (col==0 || col==IMG_W-1 || row==0 || row==IMG_H-1). When set, mag_out=0. dir_out is still computed.

## Timing
- Latency: 2 cycles from valid_in to valid_out, with fixed alignment for all outputs.
  - Stage 1 registers m, dir, border, eof.
  - Stage 2 applies the border mask and registers the outputs.
- valid_out is a pure 2-deep delay of valid_in. Bubbles are preserved exactly.
- Data outputs hold their last value while valid_out=0.
- Reset:
  - All outputs, both stage registers, and the col/row counters go to 0. Reset clears in-flight pixels.
  - After reset, the first pixel is treated as (0,0) even without sof_in.
- valid_in held high continuously gives one output per cycle with no stall.
- Frame wrap coincides with valid_in plus sof_in: sof wins, and the result is the same (0,0).

## Structure
- Shared package cordic_pkg holds:
  - ANGLE_W=32;
  - angle constants ANG_22_5=32'h1000_0000 and ANG_180=32'h8000_0000;
  - a 2-bit direction enum DIR_0/DIR_45/DIR_90/DIR_135.
- One sub-module, pix_pos_cnt: col/row counters with sof sync. Outputs border and eof for the current pixel, combinational from the counter state and sof_in.
- The gain shift-add and direction bin stay inline.

## Test plan
- **Magnitude, positive:** x_in=1000, rot_in=0, interior pixel → 2 cycles later mag_out=609, dir_out=0, valid_out=1.
- **Magnitude, negative:** x_in=−5 → mag_out=0.
- **Direction bins:** rot_in ∈ {0x0FFF_FFFF, 0x1000_0000, 0x3000_0000, 0x5000_0000, 0x7000_0000, 0x9000_0000} → dir_out {0, 1, 2, 3, 0, 1}.
- **Border map:** IMG_W=4, IMG_H=3, twelve valid pixels x_in=100 with sof on the first → border_out=1 on all except (1,1) and (2,1). mag_out=0 on the border pixels and 61 on the interior pixels. eof_out=1 only on the 12th pixel.
- **Bubbles and resync:** valid_in pattern 1,0,1,1,0 → identical valid_out pattern 2 cycles later. sof_in on the 5th pixel of a frame → that pixel reports (0,0) with border_out=1.
- **Reset mid-stream:** rst for 1 cycle with two pixels in flight → no valid_out from them. All outputs are 0 the cycle after reset. The next pixel is treated as (0,0).
